// File: rtl/melody_pkg.sv
// -----------------------------------------------------------------------------
// melody_pkg
// Shared types and constants for the melody sequencer:
//   - state_t   : sequencer FSM states (S_GAP only exists when MELODY_SEQ_GAP_EN
//                 is defined)
//   - entry_t   : song memory word layout {note[7:5], rest[4], beats[3:0]}
//   - NOTE_*    : note codes understood by the tone divider
//   - END_BEATS : beat count that marks the end of a song
// -----------------------------------------------------------------------------
package melody_pkg;

    localparam int ENTRY_W   = 8;
    localparam int NOTE_W    = 3;
    localparam int BEATS_W   = 4;
    localparam int NOTE_LSB  = 5;
    localparam int REST_BIT  = 4;
    localparam int BEATS_LSB = 0;

    typedef struct packed {
        logic [NOTE_W-1:0]  note;
        logic               rest;
        logic [BEATS_W-1:0] beats;
    } entry_t;

    localparam logic [NOTE_W-1:0] NOTE_C5 = 3'b000;
    localparam logic [NOTE_W-1:0] NOTE_D5 = 3'b001;
    localparam logic [NOTE_W-1:0] NOTE_E5 = 3'b010;
    localparam logic [NOTE_W-1:0] NOTE_F5 = 3'b011;
    localparam logic [NOTE_W-1:0] NOTE_G5 = 3'b100;
    localparam logic [NOTE_W-1:0] NOTE_A5 = 3'b101;

    localparam logic [BEATS_W-1:0] END_BEATS = '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_PLAY  = 3'd2,
`ifdef MELODY_SEQ_GAP_EN
        S_GAP   = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    function automatic logic is_end_marker(input entry_t e);
        return e.beats == END_BEATS;
    endfunction

endpackage

// File: rtl/melody_sequencer_beat_timer.sv
// -----------------------------------------------------------------------------
// beat_timer
// Measures the length of one note: a tick counter runs 0..TICKS_PER_BEAT-1 and
// a beat counter, loaded with the entry's beat count, decrements at each tick
// wrap. `expired` is high for exactly the last enabled cycle of the note.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   clear       : return both counters to zero (playback aborted)
//   load        : restart the tick counter and load load_beats
//   load_beats  : number of beats of the note about to play
//   en          : count this cycle (high while the note plays)
//   expired     : last cycle of the loaded note
// -----------------------------------------------------------------------------
module beat_timer
    import melody_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 25_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic [BEATS_W-1:0] load_beats,
    input  logic               en,
    output logic               expired
);

    localparam int                TICK_W    = $clog2(TICKS_PER_BEAT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);

    logic [TICK_W-1:0]  tick_cnt;
    logic [BEATS_W-1:0] beat_cnt;
    logic               tick_wrap;

    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign expired   = en && tick_wrap && (beat_cnt == BEATS_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            tick_cnt <= '0;
            beat_cnt <= '0;
        end else if (load) begin
            tick_cnt <= '0;
            beat_cnt <= load_beats;
        end else if (en) begin
            if (tick_wrap) begin
                tick_cnt <= '0;
                beat_cnt <= beat_cnt - BEATS_W'(1);
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
// Plays a melody stored in a small writable song memory by driving the tone
// divider's note select and an audibility gate. Each entry holds a note code,
// a rest flag and a duration in beats; a zero beat count ends the song.
//
// Build option: define MELODY_SEQ_GAP_EN to insert GAP_TICKS cycles of silence
// after every note; without it playback is legato.
//
// Ports:
//   clk, rst_n : 100 MHz clock, synchronous active-low reset
//   start      : begin playback at entry 0 (only while idle)
//   stop       : abort playback, outputs return to reset values
//   loop_en    : at end of song, restart from entry 0 instead of finishing
//   wr_en, wr_addr, wr_data : song memory write port
//   note_sel   : note code for the tone divider
//   note_en    : 1 = audible (gates the divider's output)
//   busy       : sequencer not idle
//   done       : one-cycle pulse when a non-looping song finishes
//   step       : index of the entry being played
// -----------------------------------------------------------------------------
module melody_sequencer
    import melody_pkg::*;
#(
    parameter  int TICKS_PER_BEAT = 25_000_000,
    parameter  int GAP_TICKS      = 1_000_000,
    parameter  int DEPTH          = 16,
    localparam int ADDR_W         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic [2:0]        note_sel,
    output logic              note_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] step
);

    // Elaboration-time parameter sanity checks.
    if (TICKS_PER_BEAT < 2) begin : g_bad_ticks
        $error("melody_sequencer: TICKS_PER_BEAT must be at least 2");
    end
    if (GAP_TICKS < 1) begin : g_bad_gap
        $error("melody_sequencer: GAP_TICKS must be at least 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("melody_sequencer: DEPTH must be a power of two, at least 2");
    end

    state_t state;
    entry_t mem [DEPTH];
    entry_t fetch_entry;

    logic              timer_expired;
    logic              last_entry;
    logic              loop_restart;
    state_t            eos_state;
    logic [ADDR_W-1:0] eos_step;
    state_t            adv_state;
    logic [ADDR_W-1:0] adv_step;

`ifdef MELODY_SEQ_GAP_EN
    localparam int               GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

    logic [GAP_W-1:0] gap_cnt;
`endif

    // NOTE: the song memory has no reset; its contents are defined only by
    // writes, which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= entry_t'(wr_data);
        end
    end

    // Combinational read: a write in the same cycle lands at the clock edge,
    // so FETCH always sees the previous contents.
    assign fetch_entry = mem[step];

    // Where to go when the song ends, and where to go after finishing a note.
    // NOTE: every signal driven here gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        last_entry   = (step == ADDR_W'(DEPTH - 1));
        loop_restart = loop_en && (step != '0);
        eos_state    = loop_restart ? S_FETCH : S_DONE;
        eos_step     = loop_restart ? '0 : step;
        adv_state    = last_entry ? eos_state : S_FETCH;
        adv_step     = last_entry ? eos_step : step + ADDR_W'(1);
    end

    beat_timer #(
        .TICKS_PER_BEAT (TICKS_PER_BEAT)
    ) u_beat_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (stop),
        .load       (state == S_FETCH),
        .load_beats (fetch_entry.beats),
        .en         (state == S_PLAY),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; stop takes the same path because it must
        // restore exactly the reset values.
        if (!rst_n || stop) begin
            state    <= S_IDLE;
            note_sel <= '0;
            note_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            step     <= '0;
`ifdef MELODY_SEQ_GAP_EN
            gap_cnt  <= '0;
`endif
        end else begin
            // NOTE: this default is overridden by a later non-blocking
            // assignment in the same cycle when a song finishes; the last
            // scheduled update wins.
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                        step  <= '0;
                    end
                end

                S_FETCH: begin
                    if (is_end_marker(fetch_entry)) begin
                        state <= eos_state;
                        step  <= eos_step;
                        done  <= (eos_state == S_DONE);
                    end else begin
                        state    <= S_PLAY;
                        note_sel <= fetch_entry.note;
                        note_en  <= !fetch_entry.rest;
                    end
                end

                S_PLAY: begin
                    if (timer_expired) begin
                        note_en <= 1'b0;
`ifdef MELODY_SEQ_GAP_EN
                        state   <= S_GAP;
                        gap_cnt <= '0;
`else
                        state   <= adv_state;
                        step    <= adv_step;
                        done    <= (adv_state == S_DONE);
`endif
                    end
                end

`ifdef MELODY_SEQ_GAP_EN
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= adv_state;
                        step  <= adv_step;
                        done  <= (adv_state == S_DONE);
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
`endif

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    note_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// -----------------------------------------------------------------------------
// tb_melody_sequencer
// Self-checking bench for melody_sequencer (TICKS_PER_BEAT=4, GAP_TICKS=2,
// DEPTH=16). A reference model expands the song memory into the expected
// cycle-by-cycle output sequence and each scenario task compares against it.
// -----------------------------------------------------------------------------
module tb_melody_sequencer;

    localparam int TPB   = 4;
    localparam int DEPTH = 16;
`ifdef MELODY_SEQ_GAP_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] note_sel;
    logic       note_en;
    logic       busy;
    logic       done;
    logic [3:0] step;

    int tests_run = 0;
    int failures  = 0;

    melody_sequencer #(
        .TICKS_PER_BEAT (TPB),
        .GAP_TICKS      (2),
        .DEPTH          (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .note_sel (note_sel),
        .note_en  (note_en),
        .busy     (busy),
        .done     (done),
        .step     (step)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    logic [7:0] song [DEPTH];

    typedef struct {
        logic [2:0] sel;
        logic       en;
        logic       busy;
        logic       done;
        logic [3:0] step;
        bit         chk_sel;
        bit         chk_step;
    } exp_t;

    exp_t trace [$];

    function automatic void push_exp(input logic [2:0] sel, input logic en,
                                     input logic bsy, input logic dn,
                                     input logic [3:0] stp,
                                     input bit chk_sel, input bit chk_step);
        exp_t e;
        e.sel = sel; e.en = en; e.busy = bsy; e.done = dn; e.step = stp;
        e.chk_sel = chk_sel; e.chk_step = chk_step;
        trace.push_back(e);
    endfunction

    // Expected outputs from the first cycle after start is sampled: every entry
    // costs one fetch cycle, beats*TPB note cycles and GAP silent cycles.
    function automatic void build_trace(input bit loop, input int limit);
        int         idx    = 0;
        logic [2:0] sel    = 3'b000;
        bit         sel_ok = 0;
        bit         fin    = 0;
        int         beats;
        trace.delete();
        while (!fin && trace.size() < limit) begin
            push_exp(sel, 1'b0, 1'b1, 1'b0, 4'(idx), sel_ok, 1);
            beats = int'(song[idx][3:0]);
            if (beats == 0) begin
                if (loop && idx != 0) idx = 0;
                else fin = 1;
            end else begin
                sel    = song[idx][7:5];
                sel_ok = 1;
                for (int k = 0; k < beats * TPB; k++)
                    push_exp(sel, !song[idx][4], 1'b1, 1'b0, 4'(idx), 1, 1);
                for (int k = 0; k < GAP; k++)
                    push_exp(sel, 1'b0, 1'b1, 1'b0, 4'(idx), 1, 1);
                if (idx == DEPTH - 1) begin
                    if (loop) idx = 0;
                    else fin = 1;
                end else begin
                    idx++;
                end
            end
        end
        if (fin) begin
            push_exp(3'b000, 1'b0, 1'b1, 1'b1, 4'd0, 0, 0);
            push_exp(3'b000, 1'b0, 1'b0, 1'b0, 4'd0, 0, 0);
        end
    endfunction

    // ------------------------------------------------------------- drivers
    task automatic load_all();
        for (int a = 0; a < DEPTH; a++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(a);
            wr_data = song[a];
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    // Start a song and compare every cycle with the model. start is toggled
    // randomly while busy (must be ignored). Optionally writes entry 0 during
    // its own fetch cycle; the fetch must see the old value.
    task automatic run_song(input string name, input bit loop, input int limit,
                            input bit collide, input logic [7:0] cdata);
        build_trace(loop, limit);
        loop_en = loop;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (trace[i]) begin
            tests_run++;
            if (note_en !== trace[i].en) begin
                failures++;
                $display("FAIL %s cyc%0d note_en got %b want %b", name, i, note_en, trace[i].en);
            end
            tests_run++;
            if (busy !== trace[i].busy) begin
                failures++;
                $display("FAIL %s cyc%0d busy got %b want %b", name, i, busy, trace[i].busy);
            end
            tests_run++;
            if (done !== trace[i].done) begin
                failures++;
                $display("FAIL %s cyc%0d done got %b want %b", name, i, done, trace[i].done);
            end
            if (trace[i].chk_sel) begin
                tests_run++;
                if (note_sel !== trace[i].sel) begin
                    failures++;
                    $display("FAIL %s cyc%0d note_sel got %b want %b", name, i, note_sel, trace[i].sel);
                end
            end
            if (trace[i].chk_step) begin
                tests_run++;
                if (step !== trace[i].step) begin
                    failures++;
                    $display("FAIL %s cyc%0d step got %0d want %0d", name, i, step, trace[i].step);
                end
            end
            start   = trace[i].busy ? 1'($urandom) : 1'b0;
            wr_en   = collide && (i == 0);
            wr_addr = 4'd0;
            wr_data = cdata;
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (collide) song[0] = cdata;
    endtask

    // Pulse stop and require reset values on every output the next cycle.
    task automatic apply_stop(input string name);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        tests_run++;
        if ({note_sel, note_en, busy, done, step} !== 10'd0) begin
            failures++;
            $display("FAIL %s after stop sel/en/busy/done/step got %b %b %b %b %0d want 0 0 0 0 0",
                     name, note_sel, note_en, busy, done, step);
        end
    endtask

    function automatic logic [7:0] rand_entry();
        return {3'($urandom_range(0, 7)), 1'($urandom), 4'($urandom_range(1, 3))};
    endfunction

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({note_sel, note_en, busy, done, step} !== 10'd0) begin
            failures++;
            $display("FAIL reset in-reset outputs got %b want 0", {note_sel, note_en, busy, done, step});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({note_sel, note_en, busy, done, step} !== 10'd0) begin
            failures++;
            $display("FAIL reset idle outputs got %b want 0", {note_sel, note_en, busy, done, step});
        end
    endtask

    task automatic test_basic();
        for (int a = 0; a < DEPTH; a++) song[a] = rand_entry();
        song[0] = {3'b000, 1'b0, 4'd2};
        song[1] = {3'b010, 1'b0, 4'd1};
        song[2] = {3'b111, 1'b1, 4'd0};
        load_all();
        run_song("basic", 0, 400, 0, 8'h00);
    endtask

    task automatic test_rest();
        song[0] = {3'b011, 1'b1, 4'd1};
        song[1] = {3'b000, 1'b0, 4'd0};
        load_all();
        run_song("rest", 0, 400, 0, 8'h00);
    endtask

    task automatic test_write_collision();
        song[0] = {3'b001, 1'b0, 4'd1};
        song[1] = {3'b000, 1'b0, 4'd0};
        load_all();
        run_song("collide_old", 0, 400, 1, {3'b100, 1'b0, 4'd2});
        run_song("collide_new", 0, 400, 0, 8'h00);
    endtask

    task automatic test_loop();
        song[0] = {3'b101, 1'b0, 4'd1};
        song[1] = {3'b001, 1'b1, 4'd1};
        song[2] = {3'b000, 1'b0, 4'd0};
        load_all();
        run_song("loop", 1, 70, 0, 8'h00);
        apply_stop("loop");
        // End marker at entry 0 never loops.
        song[0] = {3'b101, 1'b0, 4'd0};
        load_all();
        run_song("marker0", 1, 400, 0, 8'h00);
    endtask

    task automatic test_stop();
        song[0] = {3'b100, 1'b0, 4'd3};
        song[1] = {3'b010, 1'b0, 4'd1};
        song[2] = {3'b000, 1'b0, 4'd0};
        load_all();
        loop_en = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({note_sel, note_en, busy} !== {3'b100, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL stop_pre sel/en/busy got %b %b %b want 100 1 1", note_sel, note_en, busy);
        end
        apply_stop("stop");
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL stop_quiet cyc%0d done/busy got %b %b want 0 0", c, done, busy);
            end
            @(negedge clk);
        end
        run_song("restart", 0, 400, 0, 8'h00);
    endtask

    task automatic test_full_song();
        for (int a = 0; a < DEPTH; a++) song[a] = {3'($urandom_range(0, 7)), 1'($urandom), 4'($urandom_range(1, 2))};
        load_all();
        run_song("full_noloop", 0, 1000, 0, 8'h00);
        run_song("full_loop", 1, 260, 0, 8'h00);
        apply_stop("full_loop");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int len;
            bit lp;
            len = $urandom_range(1, 6);
            lp  = 1'($urandom);
            for (int a = 0; a < DEPTH; a++) song[a] = rand_entry();
            song[len] = {4'($urandom), 4'd0};
            load_all();
            run_song($sformatf("random%0d", n), lp, lp ? 90 : 400, 0, 8'h00);
            if (lp) apply_stop($sformatf("random%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rest();
        test_write_collision();
        test_loop();
        test_stop();
        test_full_song();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a stored melody by sequencing the tone divider's note select (`switch`-equivalent 3-bit code) through a small programmable song memory. Each entry gives a note code, a rest flag and a duration in beats. Upstream logic (buttons or a loader) writes entries and issues start/stop. The sequencer drives the divider's select and a gate that the audio output stage ANDs with `out_freq`.

## Interface
- `TICKS_PER_BEAT`, 25_000_000: clk cycles per beat (250 ms at 100 MHz); ≥2.
- `GAP_TICKS`, 1_000_000: silent articulation gap after each note; ≥1; used only with gap feature.
- `DEPTH`, 16: song entries; power of two.
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level-sampled; begins playback from entry 0 when idle.
- `stop`  in  1  aborts playback; priority over `start`.
- `loop_en`  in  1  sampled at end of song; 1 = restart at entry 0.
- `wr_en`  in  1  song memory write strobe.
- `wr_addr`  in  log2(DEPTH)  write address.
- `wr_data`  in  8  entry: [7:5] note code (000–101 valid), [4] rest, [3:0] beats (0 = end marker).
- `note_sel`  out  3  note code to divider select.
- `note_en`  out  1  1 = audible; gate for `out_freq`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at end of song without loop.
- `step`  out  log2(DEPTH)  index of the entry being played.

## Operation
- States: IDLE, FETCH, PLAY, GAP, DONE.
- IDLE: `start`=1 and `stop`=0 → FETCH with address 0.
- FETCH (1 cycle): latch entry[addr] into note/rest/beats registers. If beats==0 → end-of-song. Otherwise → PLAY.
- End-of-song: if `loop_en` and addr≠0 → FETCH at 0. Otherwise → DONE. An end marker at index 0 never loops.
- PLAY: lasts beats×TICKS_PER_BEAT cycles. `note_sel`=latched note. `note_en`=!rest. Then → GAP (gap build) or FETCH at addr+1.
- GAP: GAP_TICKS cycles with `note_en`=0 and `note_sel` held. Then → FETCH at addr+1.
- Address wrap: finishing entry DEPTH-1 counts as end-of-song. No wrap to a stale entry without the end-of-song rule.
- DONE (1 cycle): `done`=1 → IDLE.
- `stop`=1 in any state → IDLE next cycle. Counters clear; no `done` pulse.
- `start` while busy: ignored.
- Writes are allowed at any time and are registered. A write to the address being fetched in the same cycle gives the old data to FETCH.
- Note codes 110/111: passed through unchanged. Divider behaviour for them is its own concern.
- Arithmetic: tick counter is $clog2(TICKS_PER_BEAT) bits and counts 0..TICKS_PER_BEAT-1. A 4-bit beat counter decrements at tick wrap. No multiplier.

## Timing
- Reset values: `note_sel`=000, `note_en`=0, `busy`=0, `done`=0, `step`=0, state IDLE, memory not reset.
- All outputs are registered.
- `start` sampled at edge N → `busy`=1 from N+1 (FETCH) → `note_en`/`note_sel` valid from N+2.
- Note-to-note: last PLAY/GAP cycle, then one FETCH cycle (`note_en`=0, `note_sel` still old), then new note. Per-entry period = beats×TICKS_PER_BEAT + GAP_TICKS + 1.
- `step` updates on entry to FETCH.
- `stop` at edge N → all outputs at reset values from N+1, except memory contents.

## Configuration
- `MELODY_SEQ_GAP_EN` defined: GAP state is built and notes are separated by GAP_TICKS of silence.
- `MELODY_SEQ_GAP_EN` undefined: GAP state and `GAP_TICKS` logic are absent, playback is legato, and per-entry period = beats×TICKS_PER_BEAT + 1.

## Structure
- `melody_pkg`: state enum, entry field positions/widths, note code constants (NOTE_C5=000 … NOTE_A5=101), END_BEATS=0.
- One sub-module, `beat_timer`: tick and beat counters with load/clear, and an `expired` pulse. The FSM and memory live in the top.

## Test plan
(TICKS_PER_BEAT=4, GAP_TICKS=2, gap enabled unless noted.)
- Song {000,r0,2},{010,r0,1},end; `start` 1 cycle → `note_sel` 000 for 8 cycles, 2-cycle gap, FETCH, 010 for 4 cycles, gap, `done` pulse, `busy` low.
- Rest entry {011,r1,1} → `note_en`=0 for the full 4 cycles, with `note_sel`=011.
- `loop_en`=1 on a 2-entry song → `step` sequence 0,1,0,1…, `done` never asserts. Entry 0 = end marker with `loop_en`=1 → `done` after one FETCH.
- `stop` mid-PLAY → next cycle `note_en`=0, `busy`=0, `step`=0, no `done`. A new `start` restarts at entry 0.
- All 16 entries have nonzero beats → after entry 15, `done` pulses (no loop), or `step` returns to 0 (loop).
- Build without `MELODY_SEQ_GAP_EN` → entry period = beats×4+1 cycles, with no gap cycles.
